// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared Pmod CLS definitions: byte/line types, ASCII codes and decoder FSM/cursor types.
package pmod_stand_spi_solo_pkg;

    typedef logic [7:0]   t_pmod_cls_data_byte;
    typedef logic [127:0] t_pmod_cls_ascii_line_16;

    localparam t_pmod_cls_data_byte ASCII_CLS_ESC            = 8'h1B;
    localparam t_pmod_cls_data_byte ASCII_CLS_BRACKET        = 8'h5B;
    localparam t_pmod_cls_data_byte ASCII_CLS_SEMICOLON      = 8'h3B;
    localparam t_pmod_cls_data_byte ASCII_CLS_DISP_CLR_CMD   = 8'h6A;
    localparam t_pmod_cls_data_byte ASCII_CLS_CURSOR_POS_CMD = 8'h48;
    localparam t_pmod_cls_data_byte ASCII_CLS_CHAR_ZERO      = 8'h30;
    localparam t_pmod_cls_data_byte ASCII_CLS_CHAR_NINE      = 8'h39;
    localparam t_pmod_cls_data_byte ASCII_CLS_PRINT_MIN      = 8'h20;
    localparam t_pmod_cls_data_byte ASCII_CLS_PRINT_MAX      = 8'h7E;

    typedef enum logic [1:0] {
        ST_TEXT  = 2'd0,
        ST_ESC   = 2'd1,
        ST_CSI   = 2'd2,
        ST_CLEAR = 2'd3
    } t_pmod_cls_dec_state;

    typedef struct packed {
        logic [0:0] row;
        logic [3:0] col;
    } t_pmod_cls_cursor;

endpackage

// File: rtl/pmod_cls_dec_param_acc.sv
// Saturating two-parameter decimal accumulator for ESC[ P0 ; P1 sequences.
module pmod_cls_dec_param_acc #(
    parameter logic [6:0] parm_param_max = 7'd99
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rstn_20mhz,
    input  logic       clr_i,
    input  logic       digit_vld_i,
    input  logic [3:0] digit_i,
    input  logic       sep_i,
    output logic [6:0] p0_o,
    output logic [6:0] p1_o,
    output logic       idx_o
);

    logic [1:0][6:0] p_q, p_d;
    logic            idx_q, idx_d;
    logic [6:0]      cur;
    logic [6:0]      acc;

    assign cur = p_q[idx_q];
    // Any value >= 10 overflows two decimal digits, so saturate before multiplying.
    assign acc = cur * 7'd10 + {3'b000, digit_i};

    always_comb begin
        p_d   = p_q;
        idx_d = idx_q;
        if (clr_i) begin
            p_d   = '0;
            idx_d = 1'b0;
        end else begin
            if (sep_i)
                idx_d = 1'b1;
            if (digit_vld_i) begin
                if (cur >= 7'd10)
                    p_d[idx_q] = parm_param_max;
                else
                    p_d[idx_q] = (acc > parm_param_max) ? parm_param_max : acc;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            p_q   <= '0;
            idx_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            idx_q <= idx_d;
        end
    end

    assign p0_o  = p_q[0];
    assign p1_o  = p_q[1];
    assign idx_o = idx_q;

endmodule

// File: rtl/pmod_cls_ansi_decoder.sv
// Pmod CLS display model: parses printable text and ESC[j / ESC[r;cH into a 2x16 frame.
// Optional error counter output enabled by PMOD_CLS_ANSI_DECODER_ERR_CNT_EN.
module pmod_cls_ansi_decoder
    import pmod_stand_spi_solo_pkg::*;
#(
    parameter t_pmod_cls_data_byte parm_clear_char = 8'h20,
    parameter int unsigned         parm_param_max  = 99
) (
    input  logic                    i_clk_20mhz,
    input  logic                    i_rstn_20mhz,
    input  logic                    i_rx_valid,
    input  t_pmod_cls_data_byte     i_rx_byte,
    output logic                    o_rx_ready,
    output t_pmod_cls_ascii_line_16 o_line0,
    output t_pmod_cls_ascii_line_16 o_line1,
    output logic                    o_cursor_row,
    output logic [3:0]              o_cursor_col,
    output logic                    o_cmd_clear,
    output logic                    o_cmd_curpos,
    output logic                    o_seq_error
`ifdef PMOD_CLS_ANSI_DECODER_ERR_CNT_EN
   ,output logic [7:0]              o_err_count
`endif
);

    t_pmod_cls_dec_state                state_q, state_d;
    t_pmod_cls_cursor                   cur_q, cur_d;
    t_pmod_cls_ascii_line_16 [1:0]      line_q, line_d;
    logic [3:0]                         k_q, k_d;
    logic                               clr_q, clr_d, pos_q, pos_d, err_q, err_d;
    logic                               acc_clr, acc_dig, acc_sep;
    logic [6:0]                         p0, p1;
    logic                               idx;
    logic                               accept, is_digit, is_print;
    logic [6:0]                         wr_lsb, sw_lsb;

    assign o_rx_ready = (state_q != ST_CLEAR);
    assign accept     = i_rx_valid & o_rx_ready;
    assign is_digit   = (i_rx_byte >= ASCII_CLS_CHAR_ZERO) && (i_rx_byte <= ASCII_CLS_CHAR_NINE);
    assign is_print   = (i_rx_byte >= ASCII_CLS_PRINT_MIN) && (i_rx_byte <= ASCII_CLS_PRINT_MAX);
    // Column 0 sits in the top byte, so the bit offset is 8*(15-col).
    assign wr_lsb     = {~cur_q.col, 3'b000};
    assign sw_lsb     = {~k_q, 3'b000};

    pmod_cls_dec_param_acc #(
        .parm_param_max (7'(parm_param_max))
    ) u_param_acc (
        .i_clk_20mhz  (i_clk_20mhz),
        .i_rstn_20mhz (i_rstn_20mhz),
        .clr_i        (acc_clr),
        .digit_vld_i  (acc_dig),
        .digit_i      (i_rx_byte[3:0]),
        .sep_i        (acc_sep),
        .p0_o         (p0),
        .p1_o         (p1),
        .idx_o        (idx)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        line_d  = line_q;
        k_d     = k_q;
        clr_d   = 1'b0;
        pos_d   = 1'b0;
        err_d   = 1'b0;
        acc_clr = 1'b0;
        acc_dig = 1'b0;
        acc_sep = 1'b0;
        case (state_q)
            ST_TEXT: if (accept) begin
                if (i_rx_byte == ASCII_CLS_ESC) begin
                    state_d = ST_ESC;
                end else if (is_print) begin
                    line_d[cur_q.row][wr_lsb +: 8] = i_rx_byte;
                    cur_d.col = cur_q.col + 4'd1;
                    if (cur_q.col == 4'd15)
                        cur_d.row = ~cur_q.row;
                end
            end
            ST_ESC: if (accept) begin
                if (i_rx_byte == ASCII_CLS_BRACKET) begin
                    acc_clr = 1'b1;
                    state_d = ST_CSI;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_TEXT;
                end
            end
            ST_CSI: if (accept) begin
                if (is_digit) begin
                    acc_dig = 1'b1;
                end else if (i_rx_byte == ASCII_CLS_SEMICOLON) begin
                    if (idx) begin
                        err_d   = 1'b1;
                        state_d = ST_TEXT;
                    end else begin
                        acc_sep = 1'b1;
                    end
                end else if (i_rx_byte == ASCII_CLS_DISP_CLR_CMD) begin
                    clr_d   = 1'b1;
                    cur_d   = '0;
                    k_d     = 4'd0;
                    state_d = ST_CLEAR;
                end else if (i_rx_byte == ASCII_CLS_CURSOR_POS_CMD) begin
                    pos_d     = 1'b1;
                    cur_d.row = (p0 != 7'd0);
                    cur_d.col = (p1 > 7'd15) ? 4'd15 : p1[3:0];
                    state_d   = ST_TEXT;
                end else begin
                    err_d   = 1'b1;
                    state_d = (i_rx_byte == ASCII_CLS_ESC) ? ST_ESC : ST_TEXT;
                end
            end
            ST_CLEAR: begin
                line_d[0][sw_lsb +: 8] = parm_clear_char;
                line_d[1][sw_lsb +: 8] = parm_clear_char;
                k_d = k_q + 4'd1;
                if (k_q == 4'd15)
                    state_d = ST_TEXT;
            end
            default: state_d = ST_TEXT;
        endcase
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q <= ST_TEXT;
            cur_q   <= '0;
            line_q  <= {32{parm_clear_char}};
            k_q     <= 4'd0;
            clr_q   <= 1'b0;
            pos_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            line_q  <= line_d;
            k_q     <= k_d;
            clr_q   <= clr_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

`ifdef PMOD_CLS_ANSI_DECODER_ERR_CNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz)
            errcnt_q <= 8'd0;
        else if (err_d && errcnt_q != 8'hFF)
            errcnt_q <= errcnt_q + 8'd1;
    end

    assign o_err_count = errcnt_q;
`endif

    assign o_line0      = line_q[0];
    assign o_line1      = line_q[1];
    assign o_cursor_row = cur_q.row;
    assign o_cursor_col = cur_q.col;
    assign o_cmd_clear  = clr_q;
    assign o_cmd_curpos = pos_q;
    assign o_seq_error  = err_q;

endmodule

// File: tb/tb_pmod_cls_ansi_decoder.sv
// Bench for pmod_cls_ansi_decoder: directed table, corner sequences, random bytes vs a buffer-parsing model.
module tb_pmod_cls_ansi_decoder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_ready;
    logic [127:0] line0, line1;
    logic         cur_row;
    logic [3:0]   cur_col;
    logic         cmd_clear, cmd_curpos, seq_error;
`ifdef PMOD_CLS_ANSI_DECODER_ERR_CNT_EN
    logic [7:0]   err_count;
`endif

    always #25 clk = ~clk;

    pmod_cls_ansi_decoder dut (
        .i_clk_20mhz  (clk),
        .i_rstn_20mhz (rst_n),
        .i_rx_valid   (rx_valid),
        .i_rx_byte    (rx_byte),
        .o_rx_ready   (rx_ready),
        .o_line0      (line0),
        .o_line1      (line1),
        .o_cursor_row (cur_row),
        .o_cursor_col (cur_col),
        .o_cmd_clear  (cmd_clear),
        .o_cmd_curpos (cmd_curpos),
        .o_seq_error  (seq_error)
`ifdef PMOD_CLS_ANSI_DECODER_ERR_CNT_EN
       ,.o_err_count  (err_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cnt_pos, cnt_err, cnt_clr;
    logic l_pos, l_err, l_clr;
    bit   timed_out;

    // Reference: screen array plus a buffer of the escape sequence in progress.
    logic [7:0] scr [2][16];
    int         mrow, mcol, merr;
    logic [7:0] seq [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mline(input int r);
        logic [127:0] l;
        for (int c = 0; c < 16; c++) l[127-8*c -: 8] = scr[r][c];
        return l;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) scr[r][c] = 8'h20;
        mrow = 0; mcol = 0; merr = 0;
        seq.delete();
    endtask

    task automatic model_step(input logic [7:0] b, output logic ep, output logic ee, output logic ec);
        int semis;
        int p [2];
        int pi;
        ep = 0; ee = 0; ec = 0;
        semis = 0;
        foreach (seq[i]) if (seq[i] == 8'h3B) semis++;
        if (seq.size() == 0) begin
            if (b == 8'h1B) seq.push_back(b);
            else if (b >= 8'h20 && b <= 8'h7E) begin
                scr[mrow][mcol] = b;
                mcol++;
                if (mcol == 16) begin mcol = 0; mrow = 1 - mrow; end
            end
        end else if (seq.size() == 1) begin
            if (b == 8'h5B) seq.push_back(b);
            else begin ee = 1; seq.delete(); end
        end else if ((b >= 8'h30 && b <= 8'h39) || (b == 8'h3B && semis == 0)) begin
            seq.push_back(b);
        end else if (b == 8'h6A) begin
            ec = 1;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 16; c++) scr[r][c] = 8'h20;
            mrow = 0; mcol = 0;
            seq.delete();
        end else if (b == 8'h48) begin
            p[0] = 0; p[1] = 0; pi = 0;
            for (int i = 2; i < seq.size(); i++) begin
                if (seq[i] == 8'h3B) pi = 1;
                else begin
                    p[pi] = p[pi] * 10 + (int'(seq[i]) - 48);
                    if (p[pi] > 99) p[pi] = 99;
                end
            end
            mrow = (p[0] > 1) ? 1 : p[0];
            mcol = (p[1] > 15) ? 15 : p[1];
            ep = 1;
            seq.delete();
        end else begin
            ee = 1;
            seq.delete();
            if (b == 8'h1B) seq.push_back(b);
        end
        if (ee && merr < 255) merr++;
    endtask

    // Offer a byte, hold it until accepted, then capture the pulses of the following cycle.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        timed_out = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        while (!rx_ready && t < 40) begin @(negedge clk); t++; end
        if (!rx_ready) begin
            chk("ready_timeout", 128'(rx_ready), 128'(1));
            rx_valid  = 1'b0;
            timed_out = 1;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        l_pos = cmd_curpos; l_err = seq_error; l_clr = cmd_clear;
        cnt_pos += int'(l_pos); cnt_err += int'(l_err); cnt_clr += int'(l_clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_pos = 0; cnt_err = 0; cnt_clr = 0;
    endtask

    typedef struct {
        logic [95:0] bytes;
        int          n;
        logic        row;
        logic [3:0]  col;
        int          pos;
        int          err;
        logic [15:0] l0hi;
        logic [7:0]  l1c5;
    } vec_t;

    vec_t tbl [9];
    localparam logic [127:0] BLANK = {16{8'h20}};

    initial begin
        logic ep, ee, ec;
        logic [7:0] b;
        int n, r;

        tbl[0] = '{96'h4142,                   2, 1'b0, 4'd2,  0, 0, 16'h4142, 8'h20};
        tbl[1] = '{96'h1B5B313B35485A,         7, 1'b1, 4'd6,  1, 0, 16'h2020, 8'h5A};
        tbl[2] = '{96'h1B5B393B39393948,       8, 1'b1, 4'd15, 1, 0, 16'h2020, 8'h20};
        tbl[3] = '{96'h1B511B5B1B5B303B3048,  10, 1'b0, 4'd0,  1, 2, 16'h2020, 8'h20};
        tbl[4] = '{96'h1B5B4843,               4, 1'b0, 4'd1,  1, 0, 16'h4320, 8'h20};
        tbl[5] = '{96'h077F41,                 3, 1'b0, 4'd1,  0, 0, 16'h4120, 8'h20};
        tbl[6] = '{96'h1B5B3B3B6B,             5, 1'b0, 4'd1,  0, 1, 16'h6B20, 8'h20};
        tbl[7] = '{96'h1B5B317859,             5, 1'b0, 4'd1,  0, 1, 16'h5920, 8'h20};
        tbl[8] = '{96'h1B5B3248,               4, 1'b1, 4'd0,  1, 0, 16'h2020, 8'h20};

        // Reset state
        do_reset();
        #1;
        chk("rst_line0", line0, BLANK);
        chk("rst_line1", line1, BLANK);
        chk("rst_cursor", 128'({cur_row, cur_col}), 128'(0));
        chk("rst_ready", 128'(rx_ready), 128'(1));
        chk("rst_pulses", 128'({cmd_clear, cmd_curpos, seq_error}), 128'(0));

        // Directed table
        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int i = tbl[v].n - 1; i >= 0; i--) send(tbl[v].bytes[8*i +: 8]);
            chk($sformatf("tbl%0d_row", v), 128'(cur_row), 128'(tbl[v].row));
            chk($sformatf("tbl%0d_col", v), 128'(cur_col), 128'(tbl[v].col));
            chk($sformatf("tbl%0d_curpos", v), 128'(cnt_pos), 128'(tbl[v].pos));
            chk($sformatf("tbl%0d_err", v), 128'(cnt_err), 128'(tbl[v].err));
            chk($sformatf("tbl%0d_clr", v), 128'(cnt_clr), 128'(0));
            chk($sformatf("tbl%0d_l0hi", v), 128'(line0[127:112]), 128'(tbl[v].l0hi));
            chk($sformatf("tbl%0d_l1c5", v), 128'(line1[87:80]), 128'(tbl[v].l1c5));
`ifdef PMOD_CLS_ANSI_DECODER_ERR_CNT_EN
            chk($sformatf("tbl%0d_errcnt", v), 128'(err_count), 128'(tbl[v].err));
`endif
        end

        // Wrap: (0,15)->(1,0) and (1,15)->(0,0)
        do_reset();
        repeat (16) send(8'h61);
        chk("wrap_row1", 128'({cur_row, cur_col}), 128'({1'b1, 4'd0}));
        repeat (16) send(8'h62);
        chk("wrap_row0", 128'({cur_row, cur_col}), 128'(0));
        chk("wrap_l0", line0, {16{8'h61}});
        chk("wrap_l1", line1, {16{8'h62}});

        // Clear sweep: ready low for exactly 16 cycles, frame blanked
        do_reset();
        repeat (32) send(8'h78);
        chk("fill_l0", line0, {16{8'h78}});
        send(8'h1B); send(8'h5B); send(8'h6A);
        chk("clr_pulse", 128'(l_clr), 128'(1));
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 40) begin n++; @(negedge clk); end
        chk("clr_ready_low_cycles", 128'(n), 128'(16));
        chk("clr_l0", line0, BLANK);
        chk("clr_l1", line1, BLANK);
        chk("clr_cursor", 128'({cur_row, cur_col}), 128'(0));

        // Async reset mid-sweep
        repeat (32) send(8'h79);
        send(8'h1B); send(8'h5B); send(8'h6A);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_l0", line0, BLANK);
        chk("midrst_l1", line1, BLANK);
        chk("midrst_ready", 128'(rx_ready), 128'(1));
        chk("midrst_pulses", 128'({cmd_clear, cmd_curpos, seq_error}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_ready", 128'(rx_ready), 128'(1));
        chk("postrst_l1", line1, BLANK);

        // Random bytes against the reference model
        do_reset();
        model_reset();
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if      (r < 14) b = 8'h1B;
            else if (r < 26) b = 8'h5B;
            else if (r < 48) b = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 55) b = 8'h3B;
            else if (r < 59) b = 8'h6A;
            else if (r < 69) b = 8'h48;
            else if (r < 93) b = 8'($urandom_range(32, 126));
            else             b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(b);
            if (timed_out) break;
            model_step(b, ep, ee, ec);
            chk("rnd_pulses", 128'({l_clr, l_pos, l_err}), 128'({ec, ep, ee}));
            chk("rnd_cursor", 128'({cur_row, cur_col}), 128'({1'(mrow), 4'(mcol)}));
            n = 0;
            while (!rx_ready && n < 40) begin @(negedge clk); n++; end
            chk("rnd_line0", line0, mline(0));
            chk("rnd_line1", line1, mline(1));
`ifdef PMOD_CLS_ANSI_DECODER_ERR_CNT_EN
            chk("rnd_errcnt", 128'(err_count), 128'(merr));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
